// File: rtl/adc_clk_export_pkg.sv
// Shared types and the serial waveform generator for the ADC clock export path.
// Pure combinational helpers only; no state lives here.
package adc_clk_export_pkg;

    localparam int WORD_W_DEF   = 8;
    localparam int HALF_W_DEF   = 8;
    localparam int SYNC_CYC_DEF = 4;

    // Generator is sized for the widest supported build; callers slice what they need.
    localparam int MAX_WORD_W = 64;
    localparam int MAX_HALF_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_WORD_W-1:0] word;
        logic                  level;
        logic [MAX_HALF_W-1:0] cnt;
    } wave_t;

    // In drain mode the word is cut to zero from the first falling transition onward,
    // so the exported clock can only finish low.
    function automatic wave_t wave_gen(input logic                  level,
                                       input logic [MAX_HALF_W-1:0] cnt,
                                       input logic [MAX_HALF_W-1:0] hp,
                                       input int                    nbits,
                                       input logic                  drain);
        wave_t                 w;
        logic                  lv;
        logic                  alive;
        logic [MAX_HALF_W-1:0] c;
        w     = '0;
        lv    = level;
        c     = cnt;
        alive = 1'b1;
        for (int i = 0; i < MAX_WORD_W; i++) begin
            if (i < nbits) begin
                alive     = alive & lv;
                w.word[i] = drain ? alive : lv;
                if (c == hp - 1'b1) begin
                    c  = '0;
                    lv = ~lv;
                end else begin
                    c = c + 1'b1;
                end
            end
        end
        w.level = lv;
        w.cnt   = c;
        return w;
    endfunction

endpackage

// File: rtl/adc_clk_export_sync.sv
// ADC SYNC pulse generator: accepts a request only while running and idle, then holds
// o_sync high for SYNC_CYC cycles starting the next cycle; leaving RUN kills the pulse.
module adc_clk_export_sync #(
    parameter int SYNC_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    input  logic i_in_run,
    input  logic i_stay_run,
    output logic o_sync
);

    localparam int CW = (SYNC_CYC > 1) ? $clog2(SYNC_CYC) : 1;

    logic [CW-1:0] r_rem;
    logic          r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 1'b0;
            r_rem  <= '0;
        end else if (!i_stay_run) begin
            r_sync <= 1'b0;
            r_rem  <= '0;
        end else if (r_sync) begin
            if (r_rem == '0) begin
                r_sync <= 1'b0;
            end else begin
                r_rem <= r_rem - 1'b1;
            end
        end else if (i_req && i_in_run) begin
            r_sync <= 1'b1;
            r_rem  <= CW'(SYNC_CYC - 1);
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/adc_clk_export.sv
// Programmable clock waveform exporter feeding a serializer, one word per cycle, 1-cycle
// latency from enable; no backpressure. Optional edge counter under ADC_CLK_EXPORT_CNT_EN.
module adc_clk_export
    import adc_clk_export_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int HALF_W   = HALF_W_DEF,
    parameter int SYNC_CYC = SYNC_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [HALF_W-1:0] half_period,
    input  logic              sync_req,
    output logic [WORD_W-1:0] tx_word,
    output logic              tx_valid,
    output logic              running,
    output logic              sync_out,
    output logic [31:0]       edge_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_level;
    logic [HALF_W-1:0] r_cnt;
    logic [HALF_W-1:0] r_hp;
    logic [HALF_W-1:0] w_hp_in;
    wave_t             w_wave;
    logic [WORD_W-1:0] w_word_nxt;
    logic              w_valid_nxt;
    logic              w_run_nxt;
    logic              w_unused;

    assign w_hp_in = (half_period == '0) ? HALF_W'(1) : half_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable)  w_state_nxt = ST_RUN;
            ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wave = wave_gen(r_level, MAX_HALF_W'(r_cnt), MAX_HALF_W'(r_hp), WORD_W,
                             r_state == ST_DRAIN);

    assign w_unused = ^{w_wave.word[MAX_WORD_W-1:WORD_W], w_wave.cnt[MAX_HALF_W-1:HALF_W]};

    always_comb begin
        w_word_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_run_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_word_nxt  = w_wave.word[WORD_W-1:0];
                w_valid_nxt = 1'b1;
                w_run_nxt   = 1'b1;
            end
            ST_DRAIN: begin
                w_word_nxt  = w_wave.word[WORD_W-1:0];
                w_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Phase (level, cnt) carries across words; hp is only re-latched on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_hp    <= HALF_W'(1);
        end else if (r_state == ST_IDLE) begin
            if (enable) begin
                r_hp    <= w_hp_in;
                r_level <= 1'b1;
                r_cnt   <= '0;
            end
        end else begin
            r_level <= w_wave.level;
            r_cnt   <= w_wave.cnt[HALF_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word  <= '0;
            tx_valid <= 1'b0;
            running  <= 1'b0;
        end else begin
            tx_word  <= w_word_nxt;
            tx_valid <= w_valid_nxt;
            running  <= w_run_nxt;
        end
    end

    adc_clk_export_sync #(
        .SYNC_CYC (SYNC_CYC)
    ) u_sync (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (sync_req),
        .i_in_run   (r_state == ST_RUN),
        .i_stay_run (w_state_nxt == ST_RUN),
        .o_sync     (sync_out)
    );

`ifdef ADC_CLK_EXPORT_CNT_EN
    logic        r_last;
    logic [31:0] r_edges;

    // Rising edges in a word, seeded with the last bit of the previous word.
    function automatic logic [31:0] count_rises(input logic [WORD_W-1:0] w, input logic prev);
        logic [31:0] n;
        logic        p;
        n = '0;
        p = prev;
        for (int i = 0; i < WORD_W; i++) begin
            if (w[i] && !p) n = n + 32'd1;
            p = w[i];
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b0;
            r_edges <= '0;
        end else if (w_valid_nxt) begin
            r_edges <= r_edges + count_rises(w_word_nxt, r_last);
            r_last  <= w_word_nxt[WORD_W-1];
        end else begin
            r_last  <= 1'b0;
        end
    end

    assign edge_count = r_edges;
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_adc_clk_export.sv
// Scoreboarded bench for adc_clk_export: a cycle model pushes expected outputs as stimulus
// is applied, and each DUT output word is popped and compared one cycle later.
module tb_adc_clk_export;

    localparam int WW = 8;
    localparam int HW = 8;
    localparam int SC = 4;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          enable      = 1'b0;
    logic          sync_req    = 1'b0;
    logic [HW-1:0] half_period = '0;
    logic [WW-1:0] tx_word;
    logic          tx_valid;
    logic          running;
    logic          sync_out;
    logic [31:0]   edge_count;

    always #5 clk = ~clk;

    adc_clk_export #(
        .WORD_W   (WW),
        .HALF_W   (HW),
        .SYNC_CYC (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .half_period (half_period),
        .sync_req    (sync_req),
        .tx_word     (tx_word),
        .tx_valid    (tx_valid),
        .running     (running),
        .sync_out    (sync_out),
        .edge_count  (edge_count)
    );

    typedef struct {
        logic [WW-1:0] word;
        logic          valid;
        logic          run;
        logic          sync;
        logic [31:0]   edges;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: 0=IDLE 1=RUN 2=DRAIN
    int          m_state = 0;
    logic        m_level = 1'b1;
    int          m_cnt   = 0;
    int          m_hp    = 1;
    logic        m_sync  = 1'b0;
    int          m_rem   = 0;
    logic        m_last  = 1'b0;
    logic [31:0] m_edges = '0;

    task automatic model_reset();
        m_state = 0; m_level = 1'b1; m_cnt = 0; m_hp = 1;
        m_sync  = 1'b0; m_rem = 0; m_last = 1'b0; m_edges = '0;
    endtask

    task automatic gen_word(input logic drain, output logic [WW-1:0] w);
        logic prev;
        logic cut;
        w    = '0;
        cut  = drain && !m_level;
        prev = m_level;
        for (int i = 0; i < WW; i++) begin
            if (drain && prev && !m_level) cut = 1'b1;
            w[i] = cut ? 1'b0 : m_level;
            prev = m_level;
            if (m_cnt == m_hp - 1) begin
                m_cnt   = 0;
                m_level = ~m_level;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic model_cycle();
        exp_t          e;
        int            nxt;
        logic [WW-1:0] w;
        e.word = '0; e.valid = 1'b0; e.run = 1'b0;
        nxt = m_state;
        case (m_state)
            0: if (enable) begin
                m_hp    = (half_period == 0) ? 1 : int'(half_period);
                m_level = 1'b1;
                m_cnt   = 0;
                nxt     = 1;
            end
            1: begin
                gen_word(1'b0, w);
                e.word = w; e.valid = 1'b1; e.run = 1'b1;
                if (!enable) nxt = 2;
            end
            default: begin
                gen_word(1'b1, w);
                e.word = w; e.valid = 1'b1;
                nxt = 0;
            end
        endcase
        if (nxt != 1) m_sync = 1'b0;
        else if (m_sync) begin
            if (m_rem == 0) m_sync = 1'b0;
            else m_rem--;
        end else if (sync_req && m_state == 1) begin
            m_sync = 1'b1;
            m_rem  = SC - 1;
        end
        if (e.valid) begin
            for (int i = 0; i < WW; i++) begin
                if (e.word[i] && !m_last) m_edges++;
                m_last = e.word[i];
            end
        end else begin
            m_last = 1'b0;
        end
        m_state = nxt;
        e.sync  = m_sync;
`ifdef ADC_CLK_EXPORT_CNT_EN
        e.edges = m_edges;
`else
        e.edges = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        model_cycle();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("tx_word",    32'(tx_word), 32'(e.word));
        chk("tx_valid",   32'(tx_valid), 32'(e.valid));
        chk("running",    32'(running), 32'(e.run));
        chk("sync_out",   32'(sync_out), 32'(e.sync));
        chk("edge_count", edge_count, e.edges);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"},  32'(tx_word), 32'h0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_run"},   32'(running), 32'h0);
        chk({tag, "_sync"},  32'(sync_out), 32'h0);
        chk({tag, "_edges"}, edge_count, 32'h0);
    endtask

    initial begin
        int            hi;
        logic [31:0]   edge_exp;
        logic [WW-1:0] seq3 [4];
        seq3[0] = 8'hC7; seq3[1] = 8'h71; seq3[2] = 8'h1C; seq3[3] = 8'hC7;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // half_period=4 steady run
        half_period = 8'd4; enable = 1'b1;
        cyc();
        repeat (5) begin
            cyc();
            chk("hp4_word", 32'(tx_word), 32'h0F);
        end

        // sync pulse length; second request during pulse dropped
        hi = 0;
        sync_req = 1'b1; cyc(); sync_req = 1'b0; if (sync_out) hi++;
        cyc(); if (sync_out) hi++;
        sync_req = 1'b1; cyc(); sync_req = 1'b0; if (sync_out) hi++;
        repeat (4) begin cyc(); if (sync_out) hi++; end
        chk("sync_len", 32'(hi), 32'(SC));

        // drain from hp=4
        enable = 1'b0;
        cyc();
        cyc();
        chk("drain_hp4", 32'(tx_word), 32'h0F);
        cyc();
        chk("idle_word", 32'(tx_word), 32'h0);
        chk("idle_valid", 32'(tx_valid), 32'h0);

        // sync in IDLE is dropped
        sync_req = 1'b1; cyc(); sync_req = 1'b0;
        cyc();
        chk("sync_idle", 32'(sync_out), 32'h0);

        // hp=3 sequence; half_period change during RUN ignored
        half_period = 8'd3; enable = 1'b1;
        cyc();
        half_period = 8'd7;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("hp3_seq", 32'(tx_word), 32'(seq3[k]));
        end
        enable = 1'b0;
        repeat (3) cyc();

        // hp=3 drain starting at level=1, cnt=2
        half_period = 8'd3; enable = 1'b1;
        cyc();
        enable = 1'b0;
        cyc();
        chk("hp3_first", 32'(tx_word), 32'hC7);
        cyc();
        chk("drain_hp3", 32'(tx_word), 32'h01);
        chk("drain_hp3_run", 32'(running), 32'h0);
        cyc();
        chk("idle_after_hp3", 32'(tx_valid), 32'h0);

        // half_period 0 and 1 both give 0x55
        for (int k = 0; k < 2; k++) begin
            half_period = HW'(k); enable = 1'b1;
            cyc();
            repeat (4) begin
                cyc();
                chk("hp01_word", 32'(tx_word), 32'h55);
            end
            enable = 1'b0;
            repeat (3) cyc();
        end

        // 10 words at hp=4 add 10 rising edges
        edge_exp = m_edges + 32'd10;
        half_period = 8'd4; enable = 1'b1;
        cyc();
        repeat (10) cyc();
`ifdef ADC_CLK_EXPORT_CNT_EN
        chk("edge_10", edge_count, edge_exp);
`else
        chk("edge_off", edge_count, 32'h0);
`endif

        // reset mid-RUN with sync high clears everything immediately
        sync_req = 1'b1; cyc(); sync_req = 1'b0;
        cyc();
        chk("sync_before_rst", 32'(sync_out), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_clk_export.md
Name: adc_clk_export

Overview:
- Transmit-side counterpart of the ADC clock import path.
- Generates a programmable-frequency clock waveform as parallel bit words for an output serializer (OSERDES or GT TX), which drives the ADC sample clock pins.
- Also issues an ADC SYNC pulse aligned to the running clock.
- Sits in the ADC interface next to the clock import and deserializer logic, in the fabric clock domain.

Parameters:
- WORD_W, 8: bits per fabric cycle handed to the serializer. bit0 is transmitted first.
- HALF_W, 8: width of the half-period setting.
- SYNC_CYC, 4: length of sync_out in fabric cycles.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level. Start or stop the exported clock.
- half_period  in  HALF_W  half-period in serial bit times. Value 0 is treated as 1.
- sync_req  in  1  single-cycle request for an ADC SYNC pulse.
- tx_word  out  WORD_W  waveform bits to the serializer.
- tx_valid  out  1  high while in RUN or DRAIN.
- running  out  1  high in RUN only.
- sync_out  out  1  SYNC pulse to the ADC.
- edge_count  out  32  rising edges emitted. Present only with the optional feature.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - tx_word=0, tx_valid=0, running=0, sync_out=0, edge_count=0.
  - Internal level=1, cnt=0.
  - Reset asserted mid-word forces zeros at once, with no drain.
- All outputs are registered.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - tx_word=0.
  - enable=1 sampled at edge t: latch hp=max(half_period,1), set level=1, cnt=0, go to RUN.
  - The first waveform word appears on tx_word after edge t+1, i.e. 1 cycle latency from the sampled enable to the first word.
- RUN:
  - Each cycle, compute WORD_W bits serially, bit0 first:
    - bit=level;
    - if cnt==hp-1 then cnt=0 and level=~level, else cnt=cnt+1.
  - Phase state (level, cnt) carries across words, so the waveform is continuous.
  - half_period changes during RUN are ignored. hp is re-latched only on IDLE->RUN.
  - enable=0 sampled: go to DRAIN. The next word is the drain word.
- DRAIN (one word):
  - Bits are generated normally until the first 1->0 transition.
  - That bit and all later bits in the word are 0.
  - If level=0 at the start of the word, the whole word is 0.
  - Then go to IDLE.
  - The exported clock always ends low, with no runt high pulse.
  - enable is ignored in DRAIN. A restart needs one IDLE cycle.
- Sync:
  - sync_req is accepted only in RUN with sync_out=0.
  - When accepted, sync_out is high for exactly SYNC_CYC cycles, starting the next cycle.
  - sync_req in IDLE or DRAIN, or while sync_out is high, is dropped.
  - Leaving RUN before the count ends forces sync_out low on the same edge.
- Width rule: cnt is HALF_W bits; comparing against hp-1 never underflows because hp>=1.

Optional Feature:
- Macro ADC_CLK_EXPORT_CNT_EN.
- Defined:
  - edge_count increments by the number of 0->1 transitions (including the initial start-up rising edge) emitted in each output word during RUN/DRAIN.
  - The counter wraps modulo 2^32 and clears only on reset.
- Undefined:
  - edge_count is driven constant 0 and no counter logic is built.

Decomposition:
- Package adc_clk_export_pkg holds:
  - state enum (IDLE, RUN, DRAIN);
  - default constants for WORD_W, HALF_W, SYNC_CYC;
  - a pure function that returns (word, next_level, next_cnt) from (level, cnt, hp).
- One sub-module is natural: adc_clk_export_sync, the SYNC_CYC pulse counter with its accept rule.

Test Plan:
- half_period=4, enable=1 -> after 1 cycle, tx_word=8'h0F every cycle, running=1, tx_valid=1.
- half_period=3 -> repeating sequence 8'hC7, 8'h71, 8'h1C.
- half_period=0 and half_period=1 -> tx_word=8'h55 continuous in both cases.
- half_period=4 running, then enable=0 -> one drain word 8'h0F, then tx_word=0 and tx_valid=0.
- half_period=3: drop enable so the drain word starts from state level=1, cnt=2 -> drain word 8'h01, then IDLE.
- sync_req in RUN with SYNC_CYC=4 -> sync_out high for exactly 4 cycles. A second sync_req during the pulse is ignored. sync_req in IDLE gives no pulse.
- Assert rst_n=0 mid-RUN -> all outputs 0 with no clock edge. With CNT_EN, 10 words at half_period=4 -> edge_count=10.
